// File: rtl/uart_rx_ctrl_if.sv
// Receiver-side and consumer-side signals of the UART receive controller.
// m_valid/m_ready: a head entry transfers on every rising edge where both are high.
interface uart_rx_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             uart_ready;
   logic             uart_error;
   logic [WIDTH-1:0] uart_data;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;

   modport master (
      output uart_ready, uart_error, uart_data, m_ready,
      input  m_valid, m_data
   );

   modport slave (
      input  uart_ready, uart_error, uart_data, m_ready,
      output m_valid, m_data
   );
endinterface

// File: rtl/uart_rx_ctrl.sv
// Captures one byte per UART frame-done pulse into a small FIFO, counting
// error frames and flagging overflow. Single clock, synchronous active-low reset.
module uart_rx_ctrl #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic        rx_clk,
   input  logic        rx_reset,
   uart_rx_ctrl_if.slave bus,
   output logic [4:0]  fifo_count,
   output logic [7:0]  err_count,
   output logic        ovf,
   input  logic        clr_stat,
   output logic [1:0]  dbg_state_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [4:0] FULL = 5'(DEPTH);

   typedef enum logic [1:0] {
      ST_SYNC  = 2'd0,
      ST_ARMED = 2'd1,
      ST_BUSY  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [4:0]       count_q, count_d;
   logic [7:0]       err_q, err_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic capture, push, pop, full;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      err_d    = err_q;
      ovf_d    = ovf_q;

      full    = (count_q == FULL);
      capture = (state_q == ST_ARMED) && bus.uart_ready;
      pop     = (count_q != 5'd0) && bus.m_ready;
      // A full FIFO still accepts a byte when the head leaves in the same cycle.
      push    = capture && !bus.uart_error && (!full || pop);

      case (state_q)
         ST_SYNC:  if (!bus.uart_ready) state_d = ST_ARMED;
         ST_ARMED: if (bus.uart_ready)  state_d = ST_BUSY;
         ST_BUSY:  if (!bus.uart_ready) state_d = ST_ARMED;
         default:  state_d = ST_SYNC;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + 5'd1;
         2'b01:   count_d = count_q - 5'd1;
         default: count_d = count_q;
      endcase

      if (clr_stat) begin
         err_d = 8'd0;
         ovf_d = 1'b0;
      end else begin
         if (capture && bus.uart_error && (err_q != 8'hFF)) err_d = err_q + 8'd1;
         if (capture && !bus.uart_error && full && !pop)    ovf_d = 1'b1;
      end
   end

   always_ff @(posedge rx_clk) begin
      if (!rx_reset) begin
         state_q  <= ST_SYNC;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= 5'd0;
         err_q    <= 8'd0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         err_q    <= err_d;
         ovf_q    <= ovf_d;
         if (push) mem_q[wr_ptr_q] <= bus.uart_data;
      end
   end

   assign bus.m_valid = (count_q != 5'd0);
   assign bus.m_data  = (count_q != 5'd0) ? mem_q[rd_ptr_q] : '0;
   assign fifo_count  = count_q;
   assign err_count   = err_q;
   assign ovf         = ovf_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: each task drives one scenario and checks
// hand-computed values one time unit after the clock edge.
module tb_uart_rx_ctrl;

   logic       rx_clk = 1'b0;
   logic       rx_reset = 1'b0;
   logic       clr_stat = 1'b0;
   logic [4:0] fifo_count;
   logic [7:0] err_count;
   logic       ovf;
   logic [1:0] dbg_state;

   int tests = 0;
   int fails = 0;

   uart_rx_ctrl_if #(.WIDTH(8)) bus ();

   uart_rx_ctrl #(.WIDTH(8), .DEPTH(8)) dut (
      .rx_clk      (rx_clk),
      .rx_reset    (rx_reset),
      .bus         (bus),
      .fifo_count  (fifo_count),
      .err_count   (err_count),
      .ovf         (ovf),
      .clr_stat    (clr_stat),
      .dbg_state_o (dbg_state)
   );

   always #5 rx_clk = ~rx_clk;

   task automatic tick();
      @(posedge rx_clk);
      #1;
   endtask

   task automatic do_reset();
      rx_reset = 1'b0;
      bus.uart_ready = 1'b0;
      bus.uart_error = 1'b0;
      bus.uart_data = 8'h00;
      bus.m_ready = 1'b0;
      clr_stat = 1'b0;
      tick();
      tick();
      rx_reset = 1'b1;
      tick();
   endtask

   task automatic frame(input logic [7:0] d, input logic e);
      bus.uart_ready = 1'b1;
      bus.uart_data = d;
      bus.uart_error = e;
      tick();
      bus.uart_ready = 1'b0;
      bus.uart_error = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rx_reset = 1'b0;
      bus.uart_ready = 1'b0;
      bus.uart_error = 1'b0;
      bus.uart_data = 8'h00;
      bus.m_ready = 1'b0;
      tick();
      tick();
      tests++;
      if (dbg_state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d want 0", dbg_state); end
      tests++;
      if (bus.m_valid !== 1'b0 || bus.m_data !== 8'h00) begin
         fails++; $display("FAIL reset_head got v=%b d=%h want v=0 d=00", bus.m_valid, bus.m_data);
      end
      tests++;
      if (fifo_count !== 5'd0 || err_count !== 8'd0 || ovf !== 1'b0) begin
         fails++; $display("FAIL reset_stat got cnt=%0d err=%0d ovf=%b want 0/0/0", fifo_count, err_count, ovf);
      end
      rx_reset = 1'b1;
      tick();
      tests++;
      if (dbg_state !== 2'd1) begin fails++; $display("FAIL arm_after_reset got %0d want 1", dbg_state); end
   endtask

   task automatic test_single();
      bus.uart_ready = 1'b1;
      bus.uart_data = 8'hA5;
      bus.uart_error = 1'b0;
      tick();
      tests++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== 8'hA5 || fifo_count !== 5'd1) begin
         fails++; $display("FAIL single_write got v=%b d=%h cnt=%0d want 1/a5/1", bus.m_valid, bus.m_data, fifo_count);
      end
      bus.uart_ready = 1'b0;
      bus.m_ready = 1'b1;
      tick();
      bus.m_ready = 1'b0;
      tests++;
      if (bus.m_valid !== 1'b0 || bus.m_data !== 8'h00 || fifo_count !== 5'd0) begin
         fails++; $display("FAIL single_pop got v=%b d=%h cnt=%0d want 0/00/0", bus.m_valid, bus.m_data, fifo_count);
      end
   endtask

   task automatic test_held();
      bus.uart_ready = 1'b1;
      bus.uart_data = 8'h3C;
      for (int i = 0; i < 5; i++) tick();
      bus.uart_ready = 1'b0;
      tick();
      tests++;
      if (fifo_count !== 5'd1 || bus.m_data !== 8'h3C) begin
         fails++; $display("FAIL held_ready got cnt=%0d d=%h want 1/3c", fifo_count, bus.m_data);
      end
      bus.m_ready = 1'b1;
      tick();
      tick();
      bus.m_ready = 1'b0;
      tests++;
      if (fifo_count !== 5'd0 || bus.m_valid !== 1'b0) begin
         fails++; $display("FAIL empty_ready got cnt=%0d v=%b want 0/0", fifo_count, bus.m_valid);
      end
   endtask

   task automatic test_error();
      frame(8'hFF, 1'b1);
      tests++;
      if (err_count !== 8'd1 || fifo_count !== 5'd0 || bus.m_valid !== 1'b0) begin
         fails++; $display("FAIL error_frame got err=%0d cnt=%0d v=%b want 1/0/0", err_count, fifo_count, bus.m_valid);
      end
   endtask

   task automatic test_clr_priority();
      bus.uart_ready = 1'b1;
      bus.uart_error = 1'b1;
      bus.uart_data = 8'h11;
      clr_stat = 1'b1;
      tick();
      clr_stat = 1'b0;
      bus.uart_ready = 1'b0;
      bus.uart_error = 1'b0;
      tick();
      tests++;
      if (err_count !== 8'd0) begin fails++; $display("FAIL clr_priority got err=%0d want 0", err_count); end
   endtask

   task automatic test_err_sat();
      do_reset();
      for (int i = 0; i < 255; i++) frame(8'h00, 1'b1);
      tests++;
      if (err_count !== 8'd255) begin fails++; $display("FAIL err_255 got %0d want 255", err_count); end
      frame(8'h00, 1'b1);
      tests++;
      if (err_count !== 8'd255) begin fails++; $display("FAIL err_sat got %0d want 255", err_count); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 1; i <= 9; i++) frame(8'(i), 1'b0);
      tests++;
      if (fifo_count !== 5'd8 || ovf !== 1'b1) begin
         fails++; $display("FAIL overflow got cnt=%0d ovf=%b want 8/1", fifo_count, ovf);
      end
      for (int i = 1; i <= 8; i++) begin
         tests++;
         if (bus.m_valid !== 1'b1 || bus.m_data !== 8'(i)) begin
            fails++; $display("FAIL ovf_pop%0d got v=%b d=%h want 1/%h", i, bus.m_valid, bus.m_data, 8'(i));
         end
         bus.m_ready = 1'b1;
         tick();
         bus.m_ready = 1'b0;
      end
      tests++;
      if (fifo_count !== 5'd0 || bus.m_data !== 8'h00 || ovf !== 1'b1) begin
         fails++; $display("FAIL ovf_drained got cnt=%0d d=%h ovf=%b want 0/00/1", fifo_count, bus.m_data, ovf);
      end
      clr_stat = 1'b1;
      tick();
      clr_stat = 1'b0;
      tests++;
      if (ovf !== 1'b0) begin fails++; $display("FAIL ovf_clear got %b want 0", ovf); end
   endtask

   task automatic test_full_pop_capture();
      logic [7:0] exp [8];
      do_reset();
      for (int i = 1; i <= 8; i++) frame(8'(i), 1'b0);
      bus.uart_ready = 1'b1;
      bus.uart_data = 8'h10;
      bus.m_ready = 1'b1;
      tick();
      bus.uart_ready = 1'b0;
      bus.m_ready = 1'b0;
      tick();
      tests++;
      if (fifo_count !== 5'd8 || ovf !== 1'b0) begin
         fails++; $display("FAIL full_pop_cap got cnt=%0d ovf=%b want 8/0", fifo_count, ovf);
      end
      exp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h10};
      for (int i = 0; i < 8; i++) begin
         tests++;
         if (bus.m_data !== exp[i]) begin
            fails++; $display("FAIL full_drain%0d got %h want %h", i, bus.m_data, exp[i]);
         end
         bus.m_ready = 1'b1;
         tick();
         bus.m_ready = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      frame(8'h21, 1'b0);
      frame(8'h22, 1'b0);
      bus.uart_ready = 1'b1;
      bus.uart_data = 8'h23;
      bus.m_ready = 1'b1;
      tick();
      bus.uart_ready = 1'b0;
      bus.m_ready = 1'b0;
      tests++;
      if (fifo_count !== 5'd2 || bus.m_data !== 8'h22) begin
         fails++; $display("FAIL mid_pop_cap got cnt=%0d d=%h want 2/22", fifo_count, bus.m_data);
      end
      tick();
   endtask

   task automatic test_sync();
      rx_reset = 1'b0;
      bus.uart_ready = 1'b1;
      bus.uart_data = 8'h77;
      bus.uart_error = 1'b0;
      tick();
      tick();
      rx_reset = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      tests++;
      if (fifo_count !== 5'd0 || dbg_state !== 2'd0) begin
         fails++; $display("FAIL sync_ignore got cnt=%0d st=%0d want 0/0", fifo_count, dbg_state);
      end
      bus.uart_ready = 1'b0;
      tick();
      bus.uart_ready = 1'b1;
      bus.uart_data = 8'h5A;
      tick();
      bus.uart_ready = 1'b0;
      tests++;
      if (fifo_count !== 5'd1 || bus.m_data !== 8'h5A) begin
         fails++; $display("FAIL sync_capture got cnt=%0d d=%h want 1/5a", fifo_count, bus.m_data);
      end
      tick();
   endtask

   task automatic test_mid_reset();
      frame(8'h31, 1'b0);
      frame(8'h32, 1'b0);
      tests++;
      if (fifo_count !== 5'd3) begin fails++; $display("FAIL pre_reset got cnt=%0d want 3", fifo_count); end
      rx_reset = 1'b0;
      tick();
      rx_reset = 1'b1;
      tests++;
      if (fifo_count !== 5'd0 || bus.m_valid !== 1'b0 || bus.m_data !== 8'h00) begin
         fails++; $display("FAIL mid_reset got cnt=%0d v=%b d=%h want 0/0/00", fifo_count, bus.m_valid, bus.m_data);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_held();
      test_error();
      test_clr_priority();
      test_err_sat();
      test_overflow();
      test_full_pop_capture();
      test_back_to_back();
      test_sync();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, receiver data width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, 2..16.
REQ-003 SHALL have port rx_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rx_reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port uart_ready  input  1  receiver frame-done level, high for one or more cycles per frame.
REQ-006 SHALL have port uart_error  input  1  receiver parity/stop error flag, valid while uart_ready high.
REQ-007 SHALL have port uart_data  input  WIDTH  receiver byte, valid while uart_ready high.
REQ-008 SHALL have port m_valid  output  1  FIFO head available.
REQ-009 SHALL have port m_ready  input  1  consumer accepts head.
REQ-010 SHALL have port m_data  output  WIDTH  FIFO head byte.
REQ-011 SHALL have port fifo_count  output  5  current FIFO occupancy, 0..DEPTH.
REQ-012 SHALL have port err_count  output  8  count of error frames, saturating.
REQ-013 SHALL have port ovf  output  1  sticky overflow flag.
REQ-014 SHALL have port clr_stat  input  1  one-cycle clear of err_count and ovf.

Function
REQ-015 SHALL implement a capture FSM with states SYNC, ARMED and BUSY.
REQ-016 SYNC SHALL move to ARMED on the first cycle that uart_ready=0; no capture occurs in SYNC, so a level already high at reset release is ignored.
REQ-017 ARMED SHALL move to BUSY and perform one capture in any cycle with uart_ready=1.
REQ-018 BUSY SHALL return to ARMED when uart_ready=0; a held-high uart_ready SHALL yield exactly one capture.
REQ-019 Capture SHALL sample uart_data and uart_error in the same cycle as the ARMED->BUSY transition.
REQ-020 Captured with uart_error=1 SHALL discard the byte and increment err_count by 1, holding at 255.
REQ-021 Captured with uart_error=0 SHALL write the byte into the FIFO at the end of the capture cycle.
REQ-022 After a write, m_valid SHALL be 1 in the next cycle (write-to-valid latency 1 cycle).
REQ-023 A pop SHALL occur on a cycle with m_valid=1 and m_ready=1; the next entry SHALL appear on m_data the following cycle.
REQ-024 m_valid SHALL equal (fifo_count!=0).
REQ-025 m_data SHALL be 0 whenever m_valid=0.
REQ-026 The FIFO SHALL be first-in first-out, with read and write pointers wrapping modulo DEPTH.
REQ-027 A capture while fifo_count=DEPTH and no pop that cycle SHALL drop the byte, set ovf, and leave FIFO contents unchanged.
REQ-028 Capture and pop in the same cycle at full SHALL both succeed; fifo_count stays DEPTH and ovf is unchanged.
REQ-029 Capture and pop in the same cycle at any other occupancy SHALL leave fifo_count unchanged.
REQ-030 m_ready while empty SHALL have no effect.
REQ-031 A pop of an error-discarded capture SHALL not occur, since error bytes never enter the FIFO.
REQ-032 clr_stat=1 SHALL zero err_count and ovf next cycle; clr_stat SHALL take priority, so an error or overflow in the same cycle is not recorded.
REQ-033 fifo_count SHALL be 5 bits wide for all permitted DEPTH values.

Reset
REQ-034 rx_reset=0 at a rising edge SHALL force: state SYNC, FIFO empty, pointers 0, m_valid=0, m_data=0, fifo_count=0, err_count=0, ovf=0.
REQ-035 Reset mid-operation SHALL discard all FIFO contents and any in-progress capture.
REQ-036 No output SHALL change asynchronously to rx_clk.

Verification
REQ-037 Single byte: uart_ready high 1 cycle, uart_data=0xA5, error=0 -> next cycle m_valid=1, m_data=0xA5, fifo_count=1; m_ready=1 -> next cycle m_valid=0, m_data=0.
REQ-038 Held ready: uart_ready high 5 cycles, data=0x3C -> exactly one entry, fifo_count=1.
REQ-039 Error frame: capture with uart_error=1, data=0xFF -> err_count=1, fifo_count=0, m_valid=0.
REQ-039A Error saturation: 256 error frames -> err_count=255.
REQ-040 Overflow: DEPTH=8, 9 captures 0x01..0x09, m_ready=0 -> fifo_count=8, ovf=1, pops return 0x01..0x08 in order.
REQ-040A Full pop+capture: at full, simultaneous capture of 0x10 and pop -> fifo_count=8, ovf=0, last entry 0x10.
REQ-041 Reset/SYNC: uart_ready=1 during and after reset release -> no capture until uart_ready goes 0 then 1.
REQ-041A Mid-operation reset: assert reset with 3 entries -> fifo_count=0.
REQ-041B Clear priority: clr_stat and error capture in the same cycle -> err_count=0.
